// File: rtl/fifo_uart_tx_drain.sv
// fifo_uart_tx_drain
//   Pops bytes from a TX FIFO with a registered read port and sends each one
//   as a UART 8N1 frame (start 0, data LSB first, stop 1) on serial_out.
//
// Handshake: fifo_rd_en is a single-cycle pop strobe. It is raised only in
//   IDLE, only while tx_enable=1 and fifo_empty=0, and never while rst=1.
//   The FIFO presents the popped byte on fifo_dout in the following cycle,
//   which is the cycle the block spends in LOAD.
//
// Ports:
//   clk, rst     clock, synchronous active-high reset
//   tx_enable    permits new frames; a frame already started always completes
//   fifo_empty   FIFO empty flag
//   fifo_rd_en   FIFO pop strobe
//   fifo_dout    FIFO read data, valid the cycle after fifo_rd_en
//   serial_out   UART line, idle high
//   busy         high from the pop cycle through the last stop-bit cycle
//   frame_count  frames fully transmitted, wraps at 16 bits
module fifo_uart_tx_drain #(
  parameter int CLOCK_FREQ          = 125_000_000,
  parameter int BAUD_RATE           = 115_200,
  parameter int SYMBOL_EDGE_TIME    = CLOCK_FREQ / BAUD_RATE,
  parameter int CLOCK_COUNTER_WIDTH = $clog2(SYMBOL_EDGE_TIME)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        tx_enable,
  input  logic        fifo_empty,
  output logic        fifo_rd_en,
  input  logic [7:0]  fifo_dout,
  output logic        serial_out,
  output logic        busy,
  output logic [15:0] frame_count
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    SEND = 2'd2
  } state_t;

  localparam logic [CLOCK_COUNTER_WIDTH-1:0] SYM_LAST =
    CLOCK_COUNTER_WIDTH'(SYMBOL_EDGE_TIME - 1);
  localparam logic [3:0] BIT_LAST = 4'd9;  // stop bit is the 10th symbol

  state_t                         state;
  logic [9:0]                     shift;
  logic [CLOCK_COUNTER_WIDTH-1:0] sym_cnt;
  logic [3:0]                     bit_cnt;
  logic                           pop;

  // The pop is decided combinationally in IDLE so the strobe lines up with
  // the FIFO's registered read port; gating with rst keeps a reset cycle
  // from consuming a byte.
  assign pop        = (state == IDLE) && tx_enable && !fifo_empty && !rst;
  assign fifo_rd_en = pop;
  assign busy       = (state != IDLE) || pop;
  // Outside SEND the line is held high; inside SEND it only follows shift[0],
  // which changes solely at symbol boundaries.
  assign serial_out = (state == SEND) ? shift[0] : 1'b1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      shift       <= '0;
      sym_cnt     <= '0;
      bit_cnt     <= '0;
      frame_count <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pop) state <= LOAD;
        end
        LOAD: begin
          shift   <= {1'b1, fifo_dout, 1'b0};
          sym_cnt <= '0;
          bit_cnt <= '0;
          state   <= SEND;
        end
        SEND: begin
          if (sym_cnt == SYM_LAST) begin
            sym_cnt <= '0;
            // Shift in ones so a stale bit can never drive the line low.
            shift   <= {1'b1, shift[9:1]};
            if (bit_cnt == BIT_LAST) begin
              bit_cnt     <= '0;
              frame_count <= frame_count + 16'd1;
              state       <= IDLE;
            end else begin
              bit_cnt <= bit_cnt + 4'd1;
            end
          end else begin
            sym_cnt <= sym_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_uart_tx_drain.sv
// tb_fifo_uart_tx_drain
//   Directed bench for fifo_uart_tx_drain with SYMBOL_EDGE_TIME = 10.
//   A small array-based FIFO with a registered read port feeds the DUT.
//   Every cycle the DUT outputs are compared against a timeline model:
//   a pop at cycle t owns cycles t..t+101, the line is high for t, t+1, then
//   shows frame bit k during cycles t+2+10k .. t+11+10k, and the frame count
//   steps at t+102. Literal checks after each scenario pin the model.
module tb_fifo_uart_tx_drain;

  localparam int SET      = 10;
  localparam int FRAME_CY = 10 * SET;

  // clock/reset block
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        tx_enable;
  logic        fifo_empty;
  logic        fifo_rd_en;
  logic [7:0]  fifo_dout = 8'h00;
  logic        serial_out;
  logic        busy;
  logic [15:0] frame_count;

  fifo_uart_tx_drain #(
    .CLOCK_FREQ(1000),
    .BAUD_RATE (100)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .tx_enable  (tx_enable),
    .fifo_empty (fifo_empty),
    .fifo_rd_en (fifo_rd_en),
    .fifo_dout  (fifo_dout),
    .serial_out (serial_out),
    .busy       (busy),
    .frame_count(frame_count)
  );

  // FIFO with registered read port: bench writes, this block reads.
  logic [7:0] fifo_mem [16];
  logic [7:0] wr_ptr = 8'd0;
  logic [7:0] rd_ptr = 8'd0;
  assign fifo_empty = (wr_ptr == rd_ptr);

  always @(posedge clk) begin
    if (fifo_rd_en) begin
      fifo_dout <= fifo_mem[rd_ptr[3:0]];
      rd_ptr    <= rd_ptr + 8'd1;
    end
  end

  // scoreboard / model state
  logic [7:0] exp_q[$];
  int         total = 0;
  int         bad   = 0;
  int         cyc   = 0;
  bit         m_active = 1'b0;
  int         m_start  = 0;
  logic [7:0] m_byte   = 8'h00;
  logic [15:0] m_fc    = 16'h0000;
  int         pops        = 0;
  int         busy_cycles = 0;
  int         low_cycles  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cycle=%0d got=%h want=%h", name, cyc, act, exp);
    end
  endtask

  task automatic model_check();
    int         off;
    int         idx;
    logic [9:0] frame;
    logic       exp_rd;
    logic       exp_line;
    logic       exp_busy;
    if (fifo_rd_en === 1'b1) pops++;
    if (busy === 1'b1) busy_cycles++;
    if (serial_out === 1'b0) low_cycles++;
    if (rst) begin
      check("rd_en_in_reset", {31'd0, fifo_rd_en}, 32'd0);
      m_active = 1'b0;
      m_fc     = 16'h0000;
      return;
    end
    if (m_active) begin
      off      = cyc - m_start;
      exp_rd   = 1'b0;
      exp_busy = 1'b1;
      frame    = {1'b1, m_byte, 1'b0};
      if (off < 2) begin
        exp_line = 1'b1;
      end else begin
        idx      = (off - 2) / SET;
        exp_line = frame[idx];
      end
    end else begin
      off      = 0;
      exp_rd   = tx_enable && !fifo_empty;
      exp_busy = exp_rd;
      exp_line = 1'b1;
    end
    check("fifo_rd_en",  {31'd0, fifo_rd_en}, {31'd0, exp_rd});
    check("busy",        {31'd0, busy},       {31'd0, exp_busy});
    check("serial_out",  {31'd0, serial_out}, {31'd0, exp_line});
    check("frame_count", {16'd0, frame_count}, {16'd0, m_fc});
    if (m_active) begin
      if (off == FRAME_CY + 1) begin
        m_active = 1'b0;
        m_fc     = m_fc + 16'd1;
      end
    end else if (exp_rd && exp_q.size() > 0) begin
      m_active = 1'b1;
      m_start  = cyc;
      m_byte   = exp_q.pop_front();
    end
  endtask

  // driver tasks: inputs change 1 time unit after posedge, sampled at negedge
  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      model_check();
      @(posedge clk);
      #1;
      cyc++;
    end
  endtask

  task automatic push(input logic [7:0] d);
    fifo_mem[wr_ptr[3:0]] = d;
    wr_ptr = wr_ptr + 8'd1;
    exp_q.push_back(d);
  endtask

  task automatic clear_stats();
    pops        = 0;
    busy_cycles = 0;
    low_cycles  = 0;
  endtask

  initial begin
    int p0;
    rst       = 1'b1;
    tx_enable = 1'b0;
    @(posedge clk);
    #1;
    tick(3);
    rst = 1'b0;
    check("reset_serial_out",  {31'd0, serial_out}, 32'd1);
    check("reset_busy",        {31'd0, busy},       32'd0);
    check("reset_frame_count", {16'd0, frame_count}, 32'd0);
    check("reset_rd_en",       {31'd0, fifo_rd_en}, 32'd0);

    // single frame 0xA5
    clear_stats();
    push(8'hA5);
    tx_enable = 1'b1;
    tick(110);
    check("a5_frame_count", {16'd0, frame_count}, 32'd1);
    check("a5_pops",        pops,        32'd1);
    check("a5_busy_cycles", busy_cycles, 32'd102);
    // 0xA5 frame has start + four zero data bits low = 5 symbols
    check("a5_low_cycles",  low_cycles,  32'd50);

    // back-to-back 0x00, 0xFF, 0x3C
    clear_stats();
    push(8'h00);
    push(8'hFF);
    push(8'h3C);
    tick(3 * 102 + 10);
    check("b2b_frame_count", {16'd0, frame_count}, 32'd4);
    check("b2b_pops",        pops, 32'd3);
    check("b2b_fifo_empty",  {31'd0, fifo_empty}, 32'd1);
    check("b2b_busy_cycles", busy_cycles, 32'd306);

    // idle with empty FIFO
    clear_stats();
    tick(500);
    check("empty_pops",        pops,        32'd0);
    check("empty_busy_cycles", busy_cycles, 32'd0);
    check("empty_low_cycles",  low_cycles,  32'd0);

    // tx_enable gating
    clear_stats();
    tx_enable = 1'b0;
    push(8'h11);
    push(8'h22);
    tick(20);
    check("gate_no_pop", pops, 32'd0);
    tx_enable = 1'b1;
    tick(50);
    tx_enable = 1'b0;
    tick(150);
    check("gate_one_pop",      pops, 32'd1);
    check("gate_frame_count",  {16'd0, frame_count}, 32'd5);
    check("gate_full_frame",   busy_cycles, 32'd102);
    tx_enable = 1'b1;
    tick(110);
    check("gate_second_pop",   pops, 32'd2);
    check("gate_frame_count2", {16'd0, frame_count}, 32'd6);

    // reset during data bit 4 of 0x5A
    clear_stats();
    push(8'h5A);
    push(8'h77);
    p0 = pops;
    for (int i = 0; i < 20 && pops == p0; i++) tick(1);
    check("rst_pop_seen", pops, p0 + 1);
    // now in cycle t+1 after the pop; data bit 4 spans t+52..t+61
    tick(53);
    check("rst_mid_bit4_busy", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    tick(1);
    check("rst_serial_out",  {31'd0, serial_out}, 32'd1);
    check("rst_busy",        {31'd0, busy},       32'd0);
    check("rst_frame_count", {16'd0, frame_count}, 32'd0);
    rst = 1'b0;
    clear_stats();
    tick(110);
    check("rst_next_pops",        pops, 32'd1);
    check("rst_next_frame_count", {16'd0, frame_count}, 32'd1);
    check("rst_next_fifo_empty",  {31'd0, fifo_empty}, 32'd1);

    // frame_count wrap
    force dut.frame_count = 16'hFFFF;
    m_fc = 16'hFFFF;
    tick(1);
    release dut.frame_count;
    tick(2);
    check("wrap_preload", {16'd0, frame_count}, 32'h0000_FFFF);
    push(8'hC3);
    tick(110);
    check("wrap_frame_count", {16'd0, frame_count}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fifo_uart_tx_drain.md
Name: fifo_uart_tx_drain

Overview:
Drains bytes from the transmit FIFO and serializes each one as a UART 8N1 frame on serial_out. It sits directly downstream of the TX FIFO's read side, and its output drives the board TX pin. It honours the FIFO's registered read port, where dout is valid the cycle after rd_en. It also exposes busy status and a frame counter for software/debug.

Parameters:
CLOCK_FREQ, 125_000_000, clk frequency in Hz
BAUD_RATE, 115_200, line rate in baud
SYMBOL_EDGE_TIME, CLOCK_FREQ/BAUD_RATE, clk cycles per UART symbol (integer division; must be >= 2)
CLOCK_COUNTER_WIDTH, $clog2(SYMBOL_EDGE_TIME), width of the symbol cycle counter

Ports:
clk  input  1  clock
rst  input  1  synchronous, active-high reset
tx_enable  input  1  when high, new frames may start; when low, no new pop, but any frame in flight completes
fifo_empty  input  1  FIFO empty flag
fifo_rd_en  output  1  FIFO pop strobe, at most one cycle per frame
fifo_dout  input  8  FIFO read data, valid the cycle after fifo_rd_en
serial_out  output  1  UART line, idle high
busy  output  1  high from the pop cycle through the last stop-bit cycle
frame_count  output  16  number of frames fully transmitted; wraps 0xFFFF -> 0

Behaviour:
- Reset (rst sampled high at a clk edge) forces:
  - state = IDLE
  - fifo_rd_en = 0, serial_out = 1, busy = 0, frame_count = 0
  - shift register and counters cleared
- Reset mid-frame aborts the frame immediately; the line returns high the cycle after reset. The FIFO is not re-read for the aborted byte.
- IDLE:
  - fifo_rd_en = tx_enable && !fifo_empty (combinational from state).
  - If that condition is true, go to LOAD.
  - serial_out = 1; busy = fifo_rd_en.
- LOAD (1 cycle):
  - fifo_rd_en = 0; busy = 1; serial_out = 1.
  - At the clk edge, capture {1'b1, fifo_dout, 1'b0} into a 10-bit shift register, clear the counters, go to SEND.
- SEND:
  - serial_out = shift[0]; busy = 1.
  - The symbol counter counts 0..SYMBOL_EDGE_TIME-1. On reaching SYMBOL_EDGE_TIME-1, shift right by one, increment the bit counter (4 bits), and reset the symbol counter.
  - When the 10th symbol (stop bit) completes, increment frame_count and go to IDLE.
- Bit order: start bit 0, data LSB first, stop bit 1. Each symbol is exactly SYMBOL_EDGE_TIME cycles; the frame is exactly 10*SYMBOL_EDGE_TIME cycles.
- Latency: the start bit begins 2 cycles after the cycle in which fifo_rd_en is high.
- Back-to-back: with the FIFO non-empty and tx_enable high, consecutive frames are separated by exactly 2 idle-high cycles (IDLE + LOAD).
- fifo_empty and tx_enable are ignored outside IDLE. tx_enable dropping during LOAD or SEND does not truncate the frame.
- fifo_rd_en is never asserted while fifo_empty = 1 and never for two consecutive cycles.
- serial_out is glitch-free: it changes only at symbol boundaries, or when entering or leaving SEND.

Test Plan:
- Bench params CLOCK_FREQ=1000, BAUD_RATE=100 (SYMBOL_EDGE_TIME=10).
  - Push 0xA5, tx_enable=1 -> rd_en pulses 1 cycle. The line shows 0, 1,0,1,0,0,1,0,1, 1, each bit held 10 cycles, starting 2 cycles after rd_en. frame_count becomes 1 on the cycle after the stop bit ends. busy is high for 102 cycles.
- Push 0x00, 0xFF, 0x3C back-to-back -> three frames, each 100 cycles, with 2 high cycles between them. frame_count = 3; rd_en pulses exactly 3 times; the FIFO ends empty.
- fifo_empty=1 for 500 cycles -> rd_en never asserted; serial_out stays 1; busy = 0.
- tx_enable=0 with 2 bytes queued -> no pop. Raise tx_enable -> the first frame starts. Drop tx_enable mid-first-frame -> that frame completes fully; the second byte is not popped until tx_enable returns high.
- Assert rst during data bit 4 of 0x5A -> serial_out=1, busy=0, frame_count=0 the next cycle. After release with the FIFO non-empty, the next byte is sent cleanly.
- Preload frame_count to 0xFFFF by sending 65535 frames (or force) -> the next frame wraps it to 0x0000.
